// File: rtl/sorted_insert_ctrl.sv
// Ascending-ordered 16-entry key list: stable shift-insert one key per three cycles,
// and on flush drains keys smallest-first over a valid/ready output port.
module sorted_insert_ctrl #(
    parameter int DEPTH = 16,
    parameter int KW    = 32
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [KW-1:0] in_key,
    input  logic          flush,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [KW-1:0] out_key,
    output logic [4:0]    count,
    output logic          full,
    output logic          empty,
    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        WRITE = 2'd2,
        DRAIN = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] slot_q [DEPTH];
    logic [KW-1:0] slot_d [DEPTH];
    logic [KW-1:0] key_q;
    logic [4:0]    idx_q, idx_d, idx_calc;
    logic [4:0]    count_q, count_d;
    logic          in_fire;

    assign count     = count_q;
    assign full      = (count_q == 5'(DEPTH));
    assign empty     = (count_q == 5'd0);
    assign busy      = (state_q != IDLE);
    assign in_ready  = (state_q == IDLE) && !full && !flush && rst_n;
    assign in_fire   = in_valid && in_ready;
    assign out_valid = (state_q == DRAIN);
    assign out_key   = slot_q[0];

    // Insertion slot = number of occupied entries <= key, which keeps equal keys in arrival order.
    always_comb begin
        idx_calc = '0;
        for (int s = 0; s < DEPTH; s++) begin
            if ((5'(s) < count_q) && (slot_q[s] <= key_q)) begin
                idx_calc = idx_calc + 5'd1;
            end
        end
    end

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        count_d = count_q;
        slot_d  = slot_q;
        case (state_q)
            IDLE: begin
                if (in_fire) begin
                    state_d = CALC;
                end else if (flush && !empty) begin
                    state_d = DRAIN;
                end
            end
            CALC: begin
                idx_d   = idx_calc;
                state_d = WRITE;
            end
            WRITE: begin
                if (idx_q == 5'd0) begin
                    slot_d[0] = key_q;
                end
                for (int i = 1; i < DEPTH; i++) begin
                    if (5'(i) == idx_q) begin
                        slot_d[i] = key_q;
                    end else if (5'(i) > idx_q) begin
                        slot_d[i] = slot_q[i-1];
                    end
                end
                count_d = count_q + 5'd1;
                state_d = IDLE;
            end
            DRAIN: begin
                if (out_ready) begin
                    for (int i = 0; i < DEPTH - 1; i++) begin
                        slot_d[i] = slot_q[i+1];
                    end
                    slot_d[DEPTH-1] = '0;
                    count_d = count_q - 5'd1;
                    if (count_q == 5'd1) begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Reset clears the list too, so an abandoned insert or drain leaves no stale keys.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            key_q   <= '0;
            idx_q   <= '0;
            count_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                slot_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            count_q <= count_d;
            slot_q  <= slot_d;
            if (in_fire) begin
                key_q <= in_key;
            end
        end
    end

endmodule

// File: tb/tb_sorted_insert_ctrl.sv
// Scoreboard bench for sorted_insert_ctrl: a reference sorted list feeds expected
// drain keys into a queue that is popped whenever the DUT hands out a key.
module tb_sorted_insert_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] in_key = '0;
    logic        flush = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] out_key;
    logic [4:0]  count;
    logic        full;
    logic        empty;
    logic        busy;

    int n_chk = 0;
    int n_bad = 0;
    logic [31:0] model_q[$];
    logic [31:0] exp_q[$];

    sorted_insert_ctrl #(.DEPTH(16), .KW(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_key    (in_key),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_key   (out_key),
        .count     (count),
        .full      (full),
        .empty     (empty),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    function automatic void model_ins(input logic [31:0] k);
        int p;
        p = model_q.size();
        for (int i = 0; i < model_q.size(); i++) begin
            if (model_q[i] > k) begin
                p = i;
                break;
            end
        end
        model_q.insert(p, k);
    endfunction

    // A transfer happens at the next rising edge when both are high at the falling edge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                chk("drain_extra", 32'(exp_q.size()), 32'd1);
            end else begin
                chk("drain_key", out_key, exp_q.pop_front());
            end
        end
    end

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy && n < 200) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("idle_timeout", 32'(busy), 32'd0);
    endtask

    task automatic put(input logic [31:0] k);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_key   = k;
        #1;
        while (!in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (!in_ready) begin
            chk("put_timeout", 32'(in_ready), 32'd1);
        end else begin
            @(posedge clk); #1;
            model_ins(k);
        end
        in_valid = 1'b0;
        in_key   = 32'hDEAD_BEEF;
    endtask

    task automatic drain();
        wait_idle();
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        model_q.delete();
        out_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        wait_idle();
        chk("sb_left", 32'(exp_q.size()), 32'd0);
        chk("drain_cnt", 32'(count), 32'd0);
    endtask

    initial begin
        logic       pat [5];
        logic [31:0] pk [5];

        // Reset state
        #12;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_empty", 32'(empty), 32'd1);
        chk("rst_full", 32'(full), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ovalid", 32'(out_valid), 32'd0);
        chk("rst_okey", out_key, 32'd0);
        chk("rst_iready", 32'(in_ready), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_iready", 32'(in_ready), 32'd1);

        // Ordered insert and full-rate drain with per-cycle count
        put(32'd5); put(32'd2); put(32'd9); put(32'd2);
        wait_idle();
        chk("t1_count", 32'(count), 32'd4);
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        model_q.delete();
        out_ready = 1'b1;
        flush     = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("t1_ovalid", 32'(out_valid), 32'd1);
            chk("t1_count_dr", 32'(count), 32'(4 - i));
            @(posedge clk); #1;
        end
        chk("t1_ovalid_end", 32'(out_valid), 32'd0);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_count_end", 32'(count), 32'd0);
        chk("t1_sb_left", 32'(exp_q.size()), 32'd0);

        // Fill with descending keys, then hold an overflow request
        for (int k = 15; k >= 0; k--) put(32'(k));
        wait_idle();
        chk("t2_full", 32'(full), 32'd1);
        chk("t2_count", 32'(count), 32'd16);
        in_valid = 1'b1;
        in_key   = 32'd100;
        for (int i = 0; i < 8; i++) begin
            #1;
            chk("t2_iready", 32'(in_ready), 32'd0);
            @(posedge clk); #1;
        end
        chk("t2_busy", 32'(busy), 32'd0);
        chk("t2_count_hold", 32'(count), 32'd16);
        in_valid = 1'b0;
        drain();

        // Handshake latency with in_valid held continuously
        wait_idle();
        in_valid = 1'b1;
        in_key   = 32'd7;
        #1;
        chk("t3_rdy_T", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        model_ins(32'd7);
        in_key = 32'd20;
        chk("t3_rdy_T1", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("t3_rdy_T2", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        chk("t3_rdy_T3", 32'(in_ready), 32'd1);
        chk("t3_count_T3", 32'(count), 32'd1);
        chk("t3_slot0_T3", out_key, 32'd7);
        @(posedge clk); #1;
        model_ins(32'd20);
        in_valid = 1'b0;
        wait_idle();
        chk("t3_count2", 32'(count), 32'd2);
        drain();

        // Drain backpressure; same-cycle flush blocks the insert
        put(32'd8); put(32'd3);
        wait_idle();
        foreach (model_q[i]) exp_q.push_back(model_q[i]);
        model_q.delete();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_key    = 32'd50;
        flush     = 1'b1;
        #1;
        chk("t4_iready_flush", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush    = 1'b0;
        in_valid = 1'b0;
        pat = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        pk  = '{32'd3, 32'd3, 32'd8, 32'd8, 32'd8};
        for (int i = 0; i < 5; i++) begin
            out_ready = pat[i];
            #1;
            chk("t4_ovalid", 32'(out_valid), 32'd1);
            chk("t4_okey", out_key, pk[i]);
            @(posedge clk); #1;
        end
        chk("t4_ovalid_end", 32'(out_valid), 32'd0);
        chk("t4_count_end", 32'(count), 32'd0);
        chk("t4_sb_left", 32'(exp_q.size()), 32'd0);

        // Reset asserted during WRITE with five keys held
        for (int k = 1; k <= 5; k++) put(32'(k * 10));
        wait_idle();
        in_valid = 1'b1;
        in_key   = 32'd33;
        #1;
        chk("t5_rdy", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #1;
        chk("t5_write_count", 32'(count), 32'd5);
        chk("t5_write_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        model_q.delete();
        chk("t5_rst_count", 32'(count), 32'd0);
        chk("t5_rst_empty", 32'(empty), 32'd1);
        chk("t5_rst_iready", 32'(in_ready), 32'd0);
        chk("t5_rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("t5_rel_iready", 32'(in_ready), 32'd1);
        chk("t5_rel_okey", out_key, 32'd0);
        out_ready = 1'b1;
        flush     = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            chk("t5_flush_busy", 32'(busy), 32'd0);
            chk("t5_flush_ovalid", 32'(out_valid), 32'd0);
        end
        flush = 1'b0;

        // Empty flush, then extreme and equal keys
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        @(posedge clk); #1;
        chk("t6_empty_busy", 32'(busy), 32'd0);
        put(32'hFFFF_FFFF); put(32'hFFFF_FFFF); put(32'd0);
        wait_idle();
        chk("t6_count", 32'(count), 32'd3);
        chk("t6_slot0", out_key, 32'd0);
        drain();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

endmodule

// File: doc/sorted_insert_ctrl.md
# sorted_insert_ctrl

Sequences the 16-entry shift-insert datapath to maintain an ascending-ordered list of 32-bit unsigned keys (column indices of a sparse row) for the SpMM front end. Accepts one key at a time over a valid/ready handshake, computes its insertion slot, commits the shift-insert and tracks occupancy. On a flush request it drains the list in ascending order over a second valid/ready port.

## Interface
- DEPTH, 16: list capacity in entries (slot 0 holds the smallest key).
- KW, 32: key width in bits; keys are unsigned.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  insert request.
- in_ready  out  1  request accepted when in_valid && in_ready.
- in_key  in  KW  key to insert.
- flush  in  1  level request to drain the list; sampled only in IDLE.
- out_valid  out  1  out_key valid.
- out_ready  in  1  consumer accepts out_key.
- out_key  out  KW  current smallest key (slot 0).
- count  out  5  occupied entries, 0..16.
- full  out  1  count == 16.
- empty  out  1  count == 0.
- busy  out  1  state != IDLE.

## Operation
- States: IDLE, CALC, WRITE, DRAIN. Encoding is free.
- in_ready = (state == IDLE) && !full && !flush && rst_n. Flush has priority over a same-cycle insert.
- IDLE:
  - An accepted insert registers in_key into key_q and moves to CALC.
  - Otherwise, flush && !empty moves to DRAIN.
  - flush while empty is ignored; the block stays in IDLE.
- CALC: idx_q = number of occupied slots s < count with slot[s] <= key_q. Equal keys are placed after existing equals, so insertion is stable. idx_q is in 0..count. Next state is WRITE.
- WRITE:
  - slot[i] keeps its value for i < idx_q.
  - slot[idx_q] = key_q.
  - slot[i] = slot[i-1] for i > idx_q.
  - count increments and the next state is IDLE.
  - Slot 15 is discarded by the shift. This is never valid data, because insert requires !full.
- DRAIN:
  - out_valid = 1 and out_key = slot[0].
  - On out_ready: slot[i] = slot[i+1] for i < 15, slot[15] = 0, and count decrements.
  - When a pop takes count from 1 to 0, return to IDLE.
  - Inserts are not accepted during DRAIN.
- Slots at or above count always hold 0.
- out_valid is low outside DRAIN. out_key equals slot[0] in every state.

## Timing
- Reset values:
  - State: IDLE.
  - Outputs: count = 0, empty = 1, full = 0, busy = 0, out_valid = 0, out_key = 0, in_ready = 0.
  - Internal: all slots 0, key_q = 0, idx_q = 0.
- Reset is asynchronous and may assert in any state. An in-flight insert or drain is abandoned and the list is cleared.
- Insert latency:
  - Handshake in cycle T, CALC in T+1, WRITE in T+2.
  - The updated list and count are visible from T+3.
  - in_ready is high again in T+3 at the earliest, giving one insert per 3 cycles.
- Drain timing:
  - flush is sampled in IDLE at cycle T; out_valid rises in T+1.
  - Each cycle with out_valid && out_ready pops one entry. Full-rate drain is 1 entry per cycle.
  - out_valid drops in the cycle after the last pop.
- Handshake rules:
  - out_key and out_valid are stable while out_ready is low.
  - in_key needs to be valid only in the handshake cycle.
- full and empty are decoded from registered count; they are not registered separately.
- count changes only at the end of WRITE or on a DRAIN pop; it never changes by more than 1 per cycle.

## Test plan
- Ordered insert and drain:
  - Stimulus: insert 5, 2, 9, 2; then flush with out_ready = 1.
  - Required: out_key sequence 2, 2, 5, 9 on consecutive cycles. count goes 4, 3, 2, 1, 0. Return to IDLE.
- Fill and overflow:
  - Stimulus: insert 16 descending keys 15..0; keep in_valid high with key 100.
  - Required: full = 1 and in_ready = 0, the 17th key is never accepted, and a drain yields 0..15.
- Handshake latency:
  - Stimulus: insert key 7 at T, then drive in_valid continuously.
  - Required: in_ready is low in T+1 and T+2. slot[0] = 7 and count = 1 at T+3. The next accept occurs at T+3.
- Drain backpressure:
  - Stimulus: list holds 3, 8; toggle out_ready 0, 1, 0, 0, 1.
  - Required: out_key holds 3 while stalled, then 8, then out_valid = 0.
  - Required: flush asserted with in_valid in the same cycle accepts no insert.
- Reset during WRITE:
  - Stimulus: drop rst_n in WRITE with count = 5.
  - Required: immediately count = 0, empty = 1, in_ready = 0. After release, in_ready = 1 and a flush produces no output.
- Empty flush and equal keys:
  - Stimulus: flush while empty; then insert 0xFFFFFFFF twice and 0.
  - Required: the empty flush leaves busy = 0. The drain yields 0, 0xFFFFFFFF, 0xFFFFFFFF.
